id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Decode-side operand stage of the RV32 5-stage pipeline; consumer of regFile read ports.
//  Drives regFile read addresses and selects forwarded values (EX > MEM > regFile).
//  Detects load-use hazards and owns the ID/EX pipeline register with valid/ready handshake, flush and hazard counter.
//  WB results need no forwarding: regFile writes on negedge and reads combinationally.
// PARAMETERS
//  XLEN     32  operand/data width
//  REG_AW   5   register index width
//  CTRL_W   16  opaque decoded-control payload carried ID->EX
//  CNT_W    16  width of load-use stall counter
// PORTS
//  clk            in   1       pipeline clock, all state on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  id_valid       in   1       decoded instruction present in ID
//  id_ready       out  1       ID instruction accepted this cycle
//  id_rs1, id_rs2 in   REG_AW  source register indices
//  id_use_rs1/2   in   1       instruction actually reads rs1/rs2
//  id_rd          in   REG_AW  destination index
//  id_rd_we       in   1       instruction writes rd
//  id_is_load     in   1       instruction is a load
//  id_ctrl        in   CTRL_W  decoded control payload
//  rf_rd_num1/2   out  REG_AW  = id_rs1/id_rs2 (combinational)
//  rf_rd_data1/2  in   XLEN    regFile read data
//  ex_result      in   XLEN    EX-stage ALU result for instruction held in ID/EX
//  ex_ready       in   1       EX accepts ID/EX contents this cycle
//  mem_valid      in   1       MEM stage holds valid instruction
//  mem_rd         in   REG_AW  MEM destination index
//  mem_rd_we      in   1       MEM instruction writes rd
//  mem_data       in   XLEN    MEM result (load data already aligned)
//  flush          in   1       squash ID and ID/EX (branch/jump redirect)
//  idex_valid     out  1       ID/EX register valid
//  idex_rs1_val   out  XLEN    captured operand 1
//  idex_rs2_val   out  XLEN    captured operand 2
//  idex_rd        out  REG_AW  captured rd
//  idex_rd_we     out  1       captured rd write enable
//  idex_is_load   out  1       captured load flag
//  idex_ctrl      out  CTRL_W  captured control payload
//  lu_stall_cnt   out  CNT_W   load-use stall cycles, saturating
// BEHAVIOUR
//  Reset: all idex_* outputs and lu_stall_cnt = 0; idex_valid = 0.
//  Forward operand n (per source): if rs==0 -> 0.
//   Else if idex_valid & idex_rd_we & idex_rd==rs & !idex_is_load -> ex_result.
//   Else if mem_valid & mem_rd_we & mem_rd==rs -> mem_data. Else rf_rd_data.
//  Load-use hazard lu = id_valid & idex_valid & idex_is_load & idex_rd_we & idex_rd!=0
//   & ((id_use_rs1 & id_rs1==idex_rd) | (id_use_rs2 & id_rs2==idex_rd)).
//  Priority per posedge: flush > !ex_ready > lu > normal.
//   flush: idex_valid<=0; id_ready=1 (ID instruction dropped).
//   !ex_ready: ID/EX holds all fields; id_ready=0.
//   lu & ex_ready: bubble, idex_valid<=0, other idex_* don't-care; id_ready=0; lu_stall_cnt++ (sat at all-ones).
//   normal & ex_ready: capture id_* and forwarded operands; idex_valid<=id_valid; id_ready=1.
//  Latency: one cycle ID->EX; load-use costs exactly one bubble, then value arrives via MEM forward.
//  id_ready is combinational; id_ready=1 when id_valid=0 and no stall.
//  EX and MEM both match rs: EX wins (younger).
//  rd==0 never forwarded, never stalls.
//  Async reset mid-stall: clears state immediately; next cycle normal.
// STRUCTURE
//  rv32_pkg: XLEN, REG_AW, ctrl-field typedef shared with decoder/EX.
//  Sub-module id_fwd_sel (combinational, one per source operand): per-operand forward mux, instanced twice.
//  Hazard logic and register stay in the top.
// TESTING
//  1 Reset then id: rs1=3, rf_rd_data1=0x11 -> next cycle idex_rs1_val=0x11, idex_valid=1.
//  2 ID/EX add x5 (ex_result=0x20), id reads x5; MEM x5=0x99 -> idex_rs1_val=0x20.
//  3 ID/EX lw x7, id uses rs2=x7 -> id_ready=0, bubble, cnt=1; next cycle mem x7=0xAB -> idex_rs2_val=0xAB.
//  4 ex_ready=0 three cycles -> idex_* unchanged, id_ready=0; lu present -> no count.
//  5 flush during lu stall -> idex_valid=0, id_ready=1, cnt unchanged.
//  6 rs1=0 with EX/MEM rd=0 writes 0x5 -> operand 0, no stall; rst_n low mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared RV32 widths and forwarding-source encoding used by the decode-side
// operand stage and the decoder/EX neighbours.
package id_operand_stage_pkg;

    localparam int RV_XLEN   = 32;
    localparam int RV_REG_AW = 5;
    localparam int RV_CTRL_W = 16;
    localparam int RV_CNT_W  = 16;

    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_RF   = 2'd3
    } fwd_src_e;

    typedef logic [RV_CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/id_fwd_sel.sv
// Per-operand forward mux: x0 reads zero, then EX (youngest), then MEM,
// otherwise the register file value.
module id_fwd_sel
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int REG_AW = RV_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              ex_valid,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic              mem_rd_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [XLEN-1:0]   rf_data,
    output logic [XLEN-1:0]   operand
);

    fwd_src_e src;

    // A load in EX has no data yet; the hazard logic stalls instead.
    always_comb begin
        src = FWD_RF;
        if (rs == '0)
            src = FWD_ZERO;
        else if (ex_valid && ex_rd_we && !ex_is_load && (ex_rd == rs))
            src = FWD_EX;
        else if (mem_valid && mem_rd_we && (mem_rd == rs))
            src = FWD_MEM;
    end

    always_comb begin
        operand = rf_data;
        case (src)
            FWD_ZERO: operand = '0;
            FWD_EX:   operand = ex_result;
            FWD_MEM:  operand = mem_data;
            FWD_RF:   operand = rf_data;
            default:  operand = rf_data;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage operand selection, load-use hazard detection and the ID/EX
// pipeline register with valid/ready handshake, flush and stall counter.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int REG_AW = RV_REG_AW,
    parameter int CTRL_W = RV_CTRL_W,
    parameter int CNT_W  = RV_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [REG_AW-1:0] rf_rd_num1,
    output logic [REG_AW-1:0] rf_rd_num2,
    input  logic [XLEN-1:0]   rf_rd_data1,
    input  logic [XLEN-1:0]   rf_rd_data2,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              ex_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rd_we,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              flush,
    output logic              idex_valid,
    output logic [XLEN-1:0]   idex_rs1_val,
    output logic [XLEN-1:0]   idex_rs2_val,
    output logic [REG_AW-1:0] idex_rd,
    output logic              idex_rd_we,
    output logic              idex_is_load,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [CNT_W-1:0]  lu_stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [XLEN-1:0] rs1_fwd_p0;
    logic [XLEN-1:0] rs2_fwd_p0;
    logic            lu_p0;

    assign rf_rd_num1 = id_rs1;
    assign rf_rd_num2 = id_rs2;

    id_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs         (id_rs1),
        .ex_valid   (idex_valid),
        .ex_rd_we   (idex_rd_we),
        .ex_is_load (idex_is_load),
        .ex_rd      (idex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_rd_we  (mem_rd_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_data    (rf_rd_data1),
        .operand    (rs1_fwd_p0)
    );

    id_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs         (id_rs2),
        .ex_valid   (idex_valid),
        .ex_rd_we   (idex_rd_we),
        .ex_is_load (idex_is_load),
        .ex_rd      (idex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_rd_we  (mem_rd_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_data    (rf_rd_data2),
        .operand    (rs2_fwd_p0)
    );

    always_comb begin
        lu_p0 = 1'b0;
        if (id_valid && idex_valid && idex_is_load && idex_rd_we && (idex_rd != '0))
            lu_p0 = (id_use_rs1 && (id_rs1 == idex_rd)) ||
                    (id_use_rs2 && (id_rs2 == idex_rd));
    end

    // Flush drops the ID instruction, so it counts as accepted.
    always_comb begin
        id_ready = 1'b1;
        if (flush)
            id_ready = 1'b1;
        else if (!ex_ready)
            id_ready = 1'b0;
        else if (lu_p0)
            id_ready = 1'b0;
    end

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid   <= 1'b0;
            idex_rs1_val <= '0;
            idex_rs2_val <= '0;
            idex_rd      <= '0;
            idex_rd_we   <= 1'b0;
            idex_is_load <= 1'b0;
            idex_ctrl    <= '0;
            lu_stall_cnt <= '0;
        end else if (flush) begin
            idex_valid   <= 1'b0;
        end else if (!ex_ready) begin
            idex_valid   <= idex_valid;
        end else if (lu_p0) begin
            idex_valid   <= 1'b0;
            lu_stall_cnt <= sat_inc(lu_stall_cnt);
        end else begin
            idex_valid   <= id_valid;
            idex_rs1_val <= rs1_fwd_p0;
            idex_rs2_val <= rs2_fwd_p0;
            idex_rd      <= id_rd;
            idex_rd_we   <= id_rd_we;
            idex_is_load <= id_is_load;
            idex_ctrl    <= id_ctrl;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the ID/EX stage.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_rd_we, id_is_load;
    logic [15:0] id_ctrl;
    logic [4:0]  rf_rd_num1, rf_rd_num2;
    logic [31:0] rf_rd_data1, rf_rd_data2, ex_result, mem_data;
    logic        ex_ready, mem_valid, mem_rd_we, flush;
    logic [4:0]  mem_rd;
    logic        idex_valid, idex_rd_we, idex_is_load;
    logic [31:0] idex_rs1_val, idex_rs2_val;
    logic [4:0]  idex_rd;
    logic [15:0] idex_ctrl, lu_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic        m_valid, m_we, m_load;
    logic [31:0] m_rs1, m_rs2;
    logic [4:0]  m_rd;
    logic [15:0] m_ctrl, m_cnt;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_ctrl(id_ctrl),
        .rf_rd_num1(rf_rd_num1), .rf_rd_num2(rf_rd_num2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .ex_result(ex_result), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_data(mem_data),
        .flush(flush),
        .idex_valid(idex_valid), .idex_rs1_val(idex_rs1_val), .idex_rs2_val(idex_rs2_val),
        .idex_rd(idex_rd), .idex_rd_we(idex_rd_we), .idex_is_load(idex_is_load),
        .idex_ctrl(idex_ctrl), .lu_stall_cnt(lu_stall_cnt)
    );

    // Value seen by a reader of register rs: producers searched youngest first.
    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        logic        ok  [2];
        logic [31:0] val [2];
        if (rs == 5'd0) return 32'd0;
        ok[0]  = m_valid && m_we && !m_load && (m_rd == rs);
        val[0] = ex_result;
        ok[1]  = mem_valid && mem_rd_we && (mem_rd == rs);
        val[1] = mem_data;
        for (int i = 0; i < 2; i++)
            if (ok[i]) return val[i];
        return rf;
    endfunction

    function automatic logic ref_hazard();
        if (!(id_valid && m_valid && m_load && m_we && m_rd != 5'd0)) return 1'b0;
        return (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
    endfunction

    function automatic logic ref_ready();
        if (flush) return 1'b1;
        if (!ex_ready) return 1'b0;
        return !ref_hazard();
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_load = 0; m_rs1 = 0; m_rs2 = 0;
        m_rd = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    task automatic model_commit();
        logic [31:0] o1, o2;
        o1 = ref_operand(id_rs1, rf_rd_data1);
        o2 = ref_operand(id_rs2, rf_rd_data2);
        if (flush) m_valid = 0;
        else if (!ex_ready) m_valid = m_valid;
        else if (ref_hazard()) begin
            m_valid = 0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = id_valid; m_rs1 = o1; m_rs2 = o2; m_rd = id_rd;
            m_we = id_rd_we; m_load = id_is_load; m_ctrl = id_ctrl;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_rd_we = 0; id_is_load = 0; id_ctrl = 0;
        rf_rd_data1 = 0; rf_rd_data2 = 0; ex_result = 0; ex_ready = 1;
        mem_valid = 0; mem_rd = 0; mem_rd_we = 0; mem_data = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        idle();
        id_valid = 1; id_rd = rd; id_rd_we = 1; id_is_load = ld; id_ctrl = 16'h1234;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); model_reset();
        #12;
        n_checks++;
        if ({idex_valid, idex_rs1_val, idex_rs2_val, idex_rd, idex_rd_we, idex_is_load,
             idex_ctrl, lu_stall_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b rs1=%h rs2=%h rd=%0d cnt=%0d, want all 0",
                     idex_valid, idex_rs1_val, idex_rs2_val, idex_rd, lu_stall_cnt);
        end
        rst_n = 1;
        #1;
    endtask

    task automatic test_basic_capture();
        idle();
        id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; rf_rd_data1 = 32'h11;
        id_rd = 1; id_rd_we = 1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1 || rf_rd_num1 !== 5'd3) begin
            n_fail++;
            $display("FAIL basic_ready: got ready=%0b num1=%0d, want 1 / 3", id_ready, rf_rd_num1);
        end
        tick();
        n_checks++;
        if (idex_valid !== 1'b1 || idex_rs1_val !== 32'h11) begin
            n_fail++;
            $display("FAIL basic_capture: got valid=%0b rs1=%h, want 1 / 11", idex_valid, idex_rs1_val);
        end
    endtask

    task automatic test_ex_forward();
        issue(5, 0);
        tick();
        idle();
        id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 6; id_use_rs2 = 1;
        rf_rd_data1 = 32'h55; rf_rd_data2 = 32'h66; ex_result = 32'h20;
        mem_valid = 1; mem_rd = 5; mem_rd_we = 1; mem_data = 32'h99;
        tick();
        n_checks++;
        if (idex_rs1_val !== 32'h20) begin
            n_fail++;
            $display("FAIL ex_over_mem: got %h, want 00000020", idex_rs1_val);
        end
        n_checks++;
        if (idex_rs2_val !== 32'h66) begin
            n_fail++;
            $display("FAIL rf_path: got %h, want 00000066", idex_rs2_val);
        end
    endtask

    task automatic test_load_use();
        issue(7, 1);
        tick();
        idle();
        id_valid = 1; id_rs2 = 7; id_use_rs2 = 1; id_rd = 8; id_rd_we = 1;
        rf_rd_data2 = 32'hDEAD;
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_ready: got %0b, want 0", id_ready);
        end
        tick();
        n_checks++;
        if (idex_valid !== 1'b0 || lu_stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_bubble: got valid=%0b cnt=%0d, want 0 / 1", idex_valid, lu_stall_cnt);
        end
        mem_valid = 1; mem_rd = 7; mem_rd_we = 1; mem_data = 32'hAB;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_release: got %0b, want 1", id_ready);
        end
        tick();
        n_checks++;
        if (idex_valid !== 1'b1 || idex_rs2_val !== 32'hAB || lu_stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_mem_fwd: got valid=%0b rs2=%h cnt=%0d, want 1 / ab / 1",
                     idex_valid, idex_rs2_val, lu_stall_cnt);
        end
    endtask

    task automatic test_ex_stall();
        issue(9, 1);
        id_ctrl = 16'hBEEF;
        tick();
        idle();
        id_valid = 1; id_rs1 = 9; id_use_rs1 = 1; ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (id_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %0b, want 0", i, id_ready);
            end
            tick();
            n_checks++;
            if (idex_valid !== 1'b1 || idex_rd !== 5'd9 || idex_is_load !== 1'b1 ||
                idex_ctrl !== 16'hBEEF || lu_stall_cnt !== 16'd1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%0b rd=%0d ld=%0b ctrl=%h cnt=%0d, want 1/9/1/beef/1",
                         i, idex_valid, idex_rd, idex_is_load, idex_ctrl, lu_stall_cnt);
            end
        end
        ex_ready = 1;
        tick();
        n_checks++;
        if (idex_valid !== 1'b0 || lu_stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_then_bubble: got valid=%0b cnt=%0d, want 0 / 2", idex_valid, lu_stall_cnt);
        end
    endtask

    task automatic test_flush();
        issue(10, 1);
        tick();
        idle();
        id_valid = 1; id_rs1 = 10; id_use_rs1 = 1; flush = 1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got %0b, want 1", id_ready);
        end
        tick();
        n_checks++;
        if (idex_valid !== 1'b0 || lu_stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL flush_squash: got valid=%0b cnt=%0d, want 0 / 2", idex_valid, lu_stall_cnt);
        end
        flush = 0;
    endtask

    task automatic test_x0_and_async_reset();
        issue(0, 1);
        tick();
        idle();
        id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 1; id_use_rs2 = 1;
        rf_rd_data1 = 32'h77; rf_rd_data2 = 32'h77; ex_result = 32'h5;
        mem_valid = 1; mem_rd = 0; mem_rd_we = 1; mem_data = 32'h5;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_nostall: got %0b, want 1", id_ready);
        end
        tick();
        n_checks++;
        if (idex_rs1_val !== 32'd0 || idex_rs2_val !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_zero: got rs1=%h rs2=%h, want 0 / 0", idex_rs1_val, idex_rs2_val);
        end
        issue(3, 1);
        tick();
        idle();
        id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; rf_rd_data1 = 32'hC0FFEE;
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prereset_stall: got %0b, want 0", id_ready);
        end
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if ({idex_valid, idex_rs1_val, idex_rs2_val, idex_rd, idex_rd_we, idex_is_load,
             idex_ctrl, lu_stall_cnt} !== '0 || id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0b rd=%0d cnt=%0d ready=%0b, want 0/0/0/1",
                     idex_valid, idex_rd, lu_stall_cnt, id_ready);
        end
        rst_n = 1;
        tick();
        n_checks++;
        if (idex_valid !== 1'b1 || idex_rs1_val !== 32'hC0FFEE) begin
            n_fail++;
            $display("FAIL post_reset_normal: got valid=%0b rs1=%h, want 1 / c0ffee",
                     idex_valid, idex_rs1_val);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            id_rd       = 5'($urandom_range(0, 3));
            id_rd_we    = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            id_ctrl     = 16'($urandom);
            rf_rd_data1 = $urandom;
            rf_rd_data2 = $urandom;
            ex_result   = $urandom;
            ex_ready    = ($urandom_range(0, 4) != 0);
            mem_valid   = 1'($urandom);
            mem_rd      = 5'($urandom_range(0, 3));
            mem_rd_we   = 1'($urandom);
            mem_data    = $urandom;
            flush       = ($urandom_range(0, 9) == 0);
            #1;
            n_checks++;
            if (id_ready !== ref_ready() || rf_rd_num1 !== id_rs1 || rf_rd_num2 !== id_rs2) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got ready=%0b num=%0d/%0d, want %0b %0d/%0d",
                         i, id_ready, rf_rd_num1, rf_rd_num2, ref_ready(), id_rs1, id_rs2);
            end
            tick();
            n_checks++;
            if (idex_valid !== m_valid || lu_stall_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d]: got valid=%0b cnt=%0d, want %0b %0d",
                         i, idex_valid, lu_stall_cnt, m_valid, m_cnt);
            end
            if (m_valid) begin
                n_checks++;
                if (idex_rs1_val !== m_rs1 || idex_rs2_val !== m_rs2 || idex_rd !== m_rd ||
                    idex_rd_we !== m_we || idex_is_load !== m_load || idex_ctrl !== m_ctrl) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h %h rd=%0d we=%0b ld=%0b ctrl=%h, want %h %h rd=%0d we=%0b ld=%0b ctrl=%h",
                             i, idex_rs1_val, idex_rs2_val, idex_rd, idex_rd_we, idex_is_load, idex_ctrl,
                             m_rs1, m_rs2, m_rd, m_we, m_load, m_ctrl);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_ex_forward();
        test_load_use();
        test_ex_stall();
        test_flush();
        test_x0_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
